// File: rtl/psum_accum_bank.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accum_bank
//  Summary  : Multi-pass partial-sum accumulator. It sums PSUM_BW x COL beats
//             into a DEPTH-entry register buffer over cfg_passes passes, then
//             drains each entry through an optional per-lane ReLU using a
//             valid/ready handshake.
//  Options  : Define PSUM_ACCUM_SAT_EN to get saturating lane adds and a
//             sticky sat_flag. Without it, lanes wrap in two's complement
//             and sat_flag stays 0.
//  Revision : 1.0  initial release
// ============================================================================
module psum_accum_bank #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [7:0]               cfg_passes_i,
    input  logic                     cfg_relu_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [PSUM_BW*COL-1:0]   in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [PSUM_BW*COL-1:0]   out_data_o,
    output logic [ADDR_W-1:0]        out_addr_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     sat_flag_o
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PSUM_BW*COL-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]        wr_ptr_q;
    logic [ADDR_W-1:0]        rd_ptr_q;
    logic [7:0]               pass_cnt_q;
    logic [7:0]               passes_m1_q;
    logic                     relu_q;
    logic                     sat_q;
    logic                     done_q;

    logic                     w_start;
    logic                     w_acc;
    logic                     w_rd_hs;
    logic                     w_last_beat;
    logic [PSUM_BW*COL-1:0]   w_entry;
    logic [PSUM_BW*COL-1:0]   w_rd_entry;
    logic [PSUM_BW*COL-1:0]   w_sum;
    logic [PSUM_BW*COL-1:0]   w_relu_data;
    logic [COL-1:0]           w_ovf;

    // Abort takes priority over every other action in the same cycle.
    assign w_start     = (state_q == S_IDLE)  && start_i    && !abort_i;
    assign w_acc       = (state_q == S_ACCUM) && in_valid_i && !abort_i;
    assign w_rd_hs     = (state_q == S_DRAIN) && out_ready_i && !abort_i;
    assign w_last_beat = w_acc && (wr_ptr_q == C_LAST_ADDR) && (pass_cnt_q == passes_m1_q);

    assign w_entry    = mem_q[wr_ptr_q];
    assign w_rd_entry = mem_q[rd_ptr_q];

    generate
        for (genvar i = 0; i < COL; i++) begin : g_lane
`ifdef PSUM_ACCUM_SAT_EN
            logic [PSUM_BW:0] w_wide;
            assign w_wide = {w_entry[PSUM_BW*(i+1)-1], w_entry[PSUM_BW*i +: PSUM_BW]}
                          + {in_data_i[PSUM_BW*(i+1)-1], in_data_i[PSUM_BW*i +: PSUM_BW]};
            // Overflow when the extra sign bit disagrees with the lane MSB.
            assign w_ovf[i] = w_wide[PSUM_BW] ^ w_wide[PSUM_BW-1];
            assign w_sum[PSUM_BW*i +: PSUM_BW] = !w_ovf[i] ? w_wide[PSUM_BW-1:0] :
                (w_wide[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}});
`else
            assign w_ovf[i] = 1'b0;
            assign w_sum[PSUM_BW*i +: PSUM_BW] = w_entry[PSUM_BW*i +: PSUM_BW]
                                               + in_data_i[PSUM_BW*i +: PSUM_BW];
`endif
            assign w_relu_data[PSUM_BW*i +: PSUM_BW] =
                (relu_q && w_rd_entry[PSUM_BW*(i+1)-1]) ? {PSUM_BW{1'b0}}
                                                        : w_rd_entry[PSUM_BW*i +: PSUM_BW];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_addr_o  = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                in_ready_o = 1'b1;
                if (w_last_beat) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid_o = 1'b1;
                out_data_o  = w_relu_data;
                out_addr_o  = rd_ptr_q;
                if (out_ready_i && (rd_ptr_q == C_LAST_ADDR)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    // Buffer, pointers, configuration and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pass_cnt_q  <= '0;
            passes_m1_q <= '0;
            relu_q      <= 1'b0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_start) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                pass_cnt_q  <= '0;
                // A pass count of zero runs a single pass.
                passes_m1_q <= (cfg_passes_i == 8'd0) ? 8'd0 : cfg_passes_i - 8'd1;
                relu_q      <= cfg_relu_i;
                sat_q       <= 1'b0;
            end
            if (w_acc) begin
                mem_q[wr_ptr_q] <= w_sum;
                sat_q           <= sat_q | (|w_ovf);
                if (wr_ptr_q == C_LAST_ADDR) begin
                    wr_ptr_q   <= '0;
                    pass_cnt_q <= pass_cnt_q + 8'd1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
            if (w_rd_hs) begin
                if (rd_ptr_q == C_LAST_ADDR) begin
                    rd_ptr_q <= '0;
                    done_q   <= 1'b1;
                end else begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign sat_flag_o = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_accum_bank
//  Summary  : Self-checking bench for psum_accum_bank (DEPTH=4) using an
//             integer reference model of the multi-pass accumulation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psum_accum_bank;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 2;
    localparam int DW      = PSUM_BW * COL;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        cfg_passes = 8'd0;
    logic              cfg_relu = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;
    logic              sat_flag;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integer lane values per entry.
    int  m_mem [DEPTH][COL];
    bit  m_relu;
    bit  m_sat;

    always #5 clk = ~clk;

    psum_accum_bank #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .cfg_passes_i(cfg_passes), .cfg_relu_i(cfg_relu),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_addr_o(out_addr), .busy_o(busy), .done_o(done), .sat_flag_o(sat_flag)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane sum per the arithmetic rules: clamp or wrap to PSUM_BW bits.
    function automatic int fold(input int s);
        logic [15:0] t;
`ifdef PSUM_ACCUM_SAT_EN
        if (s > 32767)  begin m_sat = 1'b1; return 32767;  end
        if (s < -32768) begin m_sat = 1'b1; return -32768; end
        return s;
`else
        t = s[15:0];
        return int'($signed(t));
`endif
    endfunction

    function automatic logic [DW-1:0] expect_entry(input int k);
        logic [DW-1:0] v;
        int            x;
        v = '0;
        for (int i = 0; i < COL; i++) begin
            x = m_mem[k][i];
            if (m_relu && x < 0) x = 0;
            v[PSUM_BW*i +: PSUM_BW] = x[15:0];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int passes, input bit relu);
        start = 1'b1; cfg_passes = passes[7:0]; cfg_relu = relu;
        tick();
        start = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            for (int i = 0; i < COL; i++) m_mem[k][i] = 0;
        m_relu = relu;
        m_sat  = 1'b0;
        check("start_in_ready", DW'(in_ready), DW'(1));
        check("start_busy", DW'(busy), DW'(1));
    endtask

    task automatic feed(input int k, input int lanes[COL]);
        logic [DW-1:0] d;
        for (int i = 0; i < COL; i++) begin
            d[PSUM_BW*i +: PSUM_BW] = lanes[i][15:0];
            m_mem[k][i] = fold(m_mem[k][i] + lanes[i]);
        end
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic feed_random_tile(input int passes);
        int l[COL];
        for (int p = 0; p < passes; p++)
            for (int k = 0; k < DEPTH; k++) begin
                for (int i = 0; i < COL; i++) l[i] = int'($urandom_range(8000)) - 4000;
                feed(k, l);
            end
    endtask

    // Drain all entries; bp_entry selects one entry held with out_ready low for two cycles.
    task automatic drain_all(input int bp_entry);
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("drain_valid_%0d", k), DW'(out_valid), DW'(1));
            check($sformatf("drain_addr_%0d", k), DW'(out_addr), DW'(k));
            check($sformatf("drain_data_%0d", k), out_data, expect_entry(k));
            if (k == bp_entry) begin
                out_ready = 1'b0;
                repeat (2) begin
                    tick();
                    check("bp_addr_hold", DW'(out_addr), DW'(k));
                    check("bp_data_hold", out_data, expect_entry(k));
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("done_pulse", DW'(done), DW'(1));
        check("busy_after_drain", DW'(busy), DW'(0));
        tick();
        check("done_one_cycle", DW'(done), DW'(0));
    endtask

    initial begin
        int l[COL];

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", DW'(in_ready), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_addr", DW'(out_addr), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_sat", DW'(sat_flag), DW'(0));
        rst_n = 1'b1;
        tick();

        // Single pass, entry k lanes = k-2
        start_tile(1, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < COL; i++) l[i] = k - 2;
            feed(k, l);
        end
        drain_all(-1);

        // Three passes of constant 5 -> 15, drain starts right after the 12th beat
        start_tile(3, 1'b0);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < DEPTH; k++) begin
                for (int i = 0; i < COL; i++) l[i] = 5;
                feed(k, l);
            end
        check("p3_in_ready_low", DW'(in_ready), DW'(0));
        check("p3_out_valid", DW'(out_valid), DW'(1));
        check("p3_lane_15", DW'(out_data[15:0]), DW'(15));
        drain_all(-1);

        // ReLU with alternating -7 / 7 lanes
        start_tile(1, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < COL; i++) l[i] = (i % 2 == 0) ? -7 : 7;
            feed(k, l);
        end
        check("relu_lane0_zero", DW'(out_data[15:0]), DW'(0));
        drain_all(-1);

        // Saturation / wrap: lane 0 = 0x7000 twice
        start_tile(2, 1'b0);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < DEPTH; k++) begin
                for (int i = 0; i < COL; i++) l[i] = int'($urandom_range(200)) - 100;
                l[0] = 32'h7000;
                feed(k, l);
            end
        check("sat_flag", DW'(sat_flag), DW'(m_sat));
`ifdef PSUM_ACCUM_SAT_EN
        check("sat_lane0", DW'(out_data[15:0]), DW'(16'h7FFF));
`else
        check("wrap_lane0", DW'(out_data[15:0]), DW'(16'hE000));
`endif
        drain_all(-1);

        // Random two-pass tile with drain back-pressure on entry 1, zero pass count = 1
        start_tile(2, 1'b0);
        feed_random_tile(2);
        drain_all(1);
        start_tile(0, 1'b1);
        feed_random_tile(1);
        check("pass0_drain", DW'(out_valid), DW'(1));
        drain_all(2);

        // Abort at pass 1 beat 2
        start_tile(2, 1'b0);
        feed_random_tile(1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < COL; i++) l[i] = 9;
            feed(k, l);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", DW'(busy), DW'(0));
        check("abort_in_ready", DW'(in_ready), DW'(0));
        check("abort_no_done", DW'(done), DW'(0));
        tick();
        check("abort_no_done_late", DW'(done), DW'(0));

        // Fresh tile after abort, then reset mid-drain
        start_tile(3, 1'b1);
        feed_random_tile(3);
        for (int k = 0; k < 2; k++) begin
            check("pre_rst_data", out_data, expect_entry(k));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", DW'(out_valid), DW'(0));
        check("mid_rst_busy", DW'(busy), DW'(0));
        check("mid_rst_out_data", out_data, '0);
        tick();
        rst_n = 1'b1;
        tick();
        start_tile(2, 1'b0);
        feed_random_tile(2);
        drain_all(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
